// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the zerocore memory-access stage.
// Width codes follow funct3[1:0] of RV64I loads and stores.
package mem_stage_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned RD_W_DEF = 5;

    localparam logic [1:0] LS_B = 2'b00;
    localparam logic [1:0] LS_H = 2'b01;
    localparam logic [1:0] LS_W = 2'b10;
    localparam logic [1:0] LS_D = 2'b11;

    typedef enum logic {
        StIdle,
        StBusy
    } mem_state_e;

    // Unshifted per-bit byte-enable mask for an access of the given width.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        m = '1;
        case (size)
            LS_B:    m = 64'h0000_0000_0000_00ff;
            LS_H:    m = 64'h0000_0000_0000_ffff;
            LS_W:    m = 64'h0000_0000_ffff_ffff;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store mask/shift, load extract/extend, misalign detect.
// Request side uses the incoming instruction; response side uses the latched load info.
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_ex_funct3,
    input  logic [2:0]  i_ex_off,
    input  logic [63:0] i_ex_wdata,
    output logic        o_misalign,
    output logic [63:0] o_st_wmask,
    output logic [63:0] o_st_wdata,
    input  logic [2:0]  i_rsp_funct3,
    input  logic [2:0]  i_rsp_off,
    input  logic [63:0] i_rsp_rdata,
    output logic [63:0] o_ld_data
);

    logic [5:0]  w_st_sh;
    logic [5:0]  w_ld_sh;
    logic [63:0] w_ld_lane;
    logic        w_ld_signed;

    assign w_st_sh    = {i_ex_off, 3'b000};
    assign o_st_wmask = size_mask(i_ex_funct3[1:0]) << w_st_sh;
    assign o_st_wdata = i_ex_wdata << w_st_sh;

    always_comb begin
        o_misalign = 1'b0;
        unique case (i_ex_funct3[1:0])
            LS_B: o_misalign = 1'b0;
            LS_H: o_misalign = i_ex_off[0];
            LS_W: o_misalign = |i_ex_off[1:0];
            LS_D: o_misalign = |i_ex_off;
        endcase
    end

    assign w_ld_sh     = {i_rsp_off, 3'b000};
    assign w_ld_lane   = i_rsp_rdata >> w_ld_sh;
    // funct3[2] set selects the unsigned variants (LBU/LHU/LWU).
    assign w_ld_signed = ~i_rsp_funct3[2];

    always_comb begin
        o_ld_data = w_ld_lane;
        unique case (i_rsp_funct3[1:0])
            LS_B: o_ld_data = {{56{w_ld_signed & w_ld_lane[7]}}, w_ld_lane[7:0]};
            LS_H: o_ld_data = {{48{w_ld_signed & w_ld_lane[15]}}, w_ld_lane[15:0]};
            LS_W: o_ld_data = {{32{w_ld_signed & w_ld_lane[31]}}, w_ld_lane[31:0]};
            LS_D: o_ld_data = w_ld_lane;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack RAM handshake and
// forwards non-memory results to write-back, stalling EX while an access is open.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RD_W = RD_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_load,
    input  logic            ex_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_res,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic            ex_rd_en,
    input  logic [RD_W-1:0] ex_rd_addr,
    output logic            stall,
    output logic            ram_req,
    output logic            ram_we,
    output logic [XLEN-1:0] ram_addr,
    output logic [XLEN-1:0] ram_wmask,
    output logic [XLEN-1:0] ram_wdata,
    input  logic [XLEN-1:0] ram_rdata,
    input  logic            ram_ack,
    output logic            wb_valid,
    output logic            wb_rd_en,
    output logic [RD_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_misalign
);

    mem_state_e      r_state;
    mem_state_e      w_state_nxt;
    logic            w_accept;
    logic            w_is_mem;
    logic            w_misalign;
    logic [XLEN-1:0] w_st_wmask;
    logic [XLEN-1:0] w_st_wdata;
    logic [XLEN-1:0] w_ld_data;

    logic            r_ram_req;
    logic            r_ram_we;
    logic [XLEN-1:0] r_ram_addr;
    logic [XLEN-1:0] r_ram_wmask;
    logic [XLEN-1:0] r_ram_wdata;
    logic [2:0]      r_ld_funct3;
    logic [2:0]      r_ld_off;
    logic            r_load;
    logic            r_rd_en;
    logic [RD_W-1:0] r_rd_addr;

    logic            r_wb_valid;
    logic            r_wb_rd_en;
    logic [RD_W-1:0] r_wb_rd_addr;
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_misalign;

    assign w_is_mem = ex_load | ex_store;

    mem_stage_lsu_align u_lsu_align (
        .i_ex_funct3  (ex_funct3),
        .i_ex_off     (ex_res[2:0]),
        .i_ex_wdata   (ex_wdata),
        .o_misalign   (w_misalign),
        .o_st_wmask   (w_st_wmask),
        .o_st_wdata   (w_st_wdata),
        .i_rsp_funct3 (r_ld_funct3),
        .i_rsp_off    (r_ld_off),
        .i_rsp_rdata  (ram_rdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (ex_valid) begin
                    w_accept = 1'b1;
                    if (w_is_mem && !w_misalign) begin
                        w_state_nxt = StBusy;
                    end
                end
            end
            StBusy: begin
                if (ram_ack) begin
                    w_state_nxt = StIdle;
                end
            end
        endcase
    end

    // Request registers: loaded on an aligned accept, held untouched until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wmask <= '0;
            r_ram_wdata <= '0;
            r_ld_funct3 <= '0;
            r_ld_off    <= '0;
            r_load      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
        end else if (w_accept && w_is_mem && !w_misalign) begin
            r_ram_req   <= 1'b1;
            r_ram_we    <= ex_store;
            r_ram_addr  <= {ex_res[XLEN-1:3], 3'b000};
            r_ram_wmask <= ex_store ? w_st_wmask : '0;
            r_ram_wdata <= ex_store ? w_st_wdata : '0;
            r_ld_funct3 <= ex_funct3;
            r_ld_off    <= ex_res[2:0];
            r_load      <= ~ex_store;
            r_rd_en     <= ex_rd_en;
            r_rd_addr   <= ex_rd_addr;
        end else if (r_state == StBusy && ram_ack) begin
            r_ram_req <= 1'b0;
            r_ram_we  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_rd_en    <= 1'b0;
            r_wb_rd_addr  <= '0;
            r_wb_data     <= '0;
            r_wb_misalign <= 1'b0;
        end else begin
            r_wb_valid    <= 1'b0;
            r_wb_misalign <= 1'b0;
            if (w_accept && !w_is_mem) begin
                r_wb_valid   <= 1'b1;
                r_wb_rd_en   <= ex_rd_en;
                r_wb_rd_addr <= ex_rd_addr;
                r_wb_data    <= ex_res;
            end else if (w_accept && w_misalign) begin
                r_wb_valid    <= 1'b1;
                r_wb_misalign <= 1'b1;
                r_wb_rd_en    <= 1'b0;
                r_wb_rd_addr  <= ex_rd_addr;
                r_wb_data     <= '0;
            end else if (r_state == StBusy && ram_ack) begin
                r_wb_valid   <= 1'b1;
                r_wb_rd_en   <= r_load & r_rd_en;
                r_wb_rd_addr <= r_rd_addr;
                r_wb_data    <= r_load ? w_ld_data : '0;
            end
        end
    end

    assign stall       = (r_state == StBusy);
    assign ram_req     = r_ram_req;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wmask   = r_ram_wmask;
    assign ram_wdata   = r_ram_wdata;
    assign wb_valid    = r_wb_valid;
    assign wb_rd_en    = r_wb_rd_en;
    assign wb_rd_addr  = r_wb_rd_addr;
    assign wb_data     = r_wb_data;
    assign wb_misalign = r_wb_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single instructions plus
// hand-written stall/hold, idle-ack and reset-abort sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_load;
    logic        ex_store;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_res;
    logic [63:0] ex_wdata;
    logic        ex_rd_en;
    logic [4:0]  ex_rd_addr;
    logic        stall;
    logic        ram_req;
    logic        ram_we;
    logic [63:0] ram_addr;
    logic [63:0] ram_wmask;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;
    logic        ram_ack;
    logic        wb_valid;
    logic        wb_rd_en;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic        wb_misalign;

    int n_vec;
    int n_miss;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_load     (ex_load),
        .ex_store    (ex_store),
        .ex_funct3   (ex_funct3),
        .ex_res      (ex_res),
        .ex_wdata    (ex_wdata),
        .ex_rd_en    (ex_rd_en),
        .ex_rd_addr  (ex_rd_addr),
        .stall       (stall),
        .ram_req     (ram_req),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wmask   (ram_wmask),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .ram_ack     (ram_ack),
        .wb_valid    (wb_valid),
        .wb_rd_en    (wb_rd_en),
        .wb_rd_addr  (wb_rd_addr),
        .wb_data     (wb_data),
        .wb_misalign (wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] res;
        logic [63:0] wd;
        logic        rd_en;
        logic [4:0]  rd;
        int          delay;
        logic [63:0] rdata;
        logic        e_mem;
        logic [63:0] e_wmask;
        logic [63:0] e_wdata;
        logic [63:0] e_wb;
        logic        e_rd_en;
        logic        e_mis;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [63:0] res, input logic [63:0] wd,
                                input logic rd_en, input logic [4:0] rd, input int delay,
                                input logic [63:0] rdata, input logic e_mem,
                                input logic [63:0] e_wmask, input logic [63:0] e_wdata,
                                input logic [63:0] e_wb, input logic e_rd_en,
                                input logic e_mis);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.res = res; v.wd = wd;
        v.rd_en = rd_en; v.rd = rd; v.delay = delay; v.rdata = rdata;
        v.e_mem = e_mem; v.e_wmask = e_wmask; v.e_wdata = e_wdata;
        v.e_wb = e_wb; v.e_rd_en = e_rd_en; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic drive_ex(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [63:0] res, input logic [63:0] wd,
                            input logic rd_en, input logic [4:0] rd);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_res = res; ex_wdata = wd; ex_rd_en = rd_en; ex_rd_addr = rd;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
        ex_res = '0; ex_wdata = '0; ex_rd_en = 1'b0; ex_rd_addr = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] e_addr;
        string       p;
        p = $sformatf("v%0d", idx);
        e_addr = v.res & ~64'd7;
        @(negedge clk);
        drive_ex(v.ld, v.st, v.f3, v.res, v.wd, v.rd_en, v.rd);
        @(posedge clk); #1;
        idle_ex();
        if (v.e_mem) begin
            for (int k = 0; k <= v.delay; k++) begin
                chk({p, ".ram_req"},   ram_req,   1'b1);
                chk({p, ".stall"},     stall,     1'b1);
                chk({p, ".ram_we"},    ram_we,    v.st);
                chk({p, ".ram_addr"},  ram_addr,  e_addr);
                chk({p, ".ram_wmask"}, ram_wmask, v.e_wmask);
                chk({p, ".ram_wdata"}, ram_wdata, v.e_wdata);
                chk({p, ".wb_valid_busy"}, wb_valid, 1'b0);
                if (k == v.delay) begin
                    ram_ack = 1'b1;
                    ram_rdata = v.rdata;
                end
                @(posedge clk); #1;
            end
            ram_ack = 1'b0;
            ram_rdata = '0;
        end else begin
            chk({p, ".ram_req"}, ram_req, 1'b0);
            chk({p, ".stall"},   stall,   1'b0);
        end
        chk({p, ".wb_valid"},    wb_valid,    1'b1);
        chk({p, ".wb_data"},     wb_data,     v.e_wb);
        chk({p, ".wb_rd_en"},    wb_rd_en,    v.e_rd_en);
        chk({p, ".wb_misalign"}, wb_misalign, v.e_mis);
        chk({p, ".ram_req_done"}, ram_req,    1'b0);
        if (v.e_rd_en) chk({p, ".wb_rd_addr"}, wb_rd_addr, v.rd);
        @(posedge clk); #1;
        chk({p, ".wb_pulse"}, wb_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] hold_addr;
        n_vec = 0;
        n_miss = 0;
        rst = 1'b1;
        ram_ack = 1'b0;
        ram_rdata = '0;
        idle_ex();

        //          ld  st  f3    res                    wd                     rde rd  dly rdata                  mem wmask                  wdata                  wb                     rde mis
        vecs[0]  = mk(0, 0, 3'd0, 64'h1234,              64'h0,                 1, 5,  0, 64'h0,                 0, 64'h0,                 64'h0,                 64'h1234,              1, 0);
        vecs[1]  = mk(0, 1, 3'd0, 64'h1003,              64'hAB,                1, 7,  3, 64'h0,                 1, 64'h0000_0000_FF00_0000, 64'h0000_0000_AB00_0000, 64'h0,              0, 0);
        vecs[2]  = mk(1, 0, 3'd1, 64'h2006,              64'h0,                 1, 3,  0, 64'h8001_0000_0000_0000, 1, 64'h0,               64'h0,                 64'hFFFF_FFFF_FFFF_8001, 1, 0);
        vecs[3]  = mk(1, 0, 3'd5, 64'h2006,              64'h0,                 1, 4,  0, 64'h8001_0000_0000_0000, 1, 64'h0,               64'h0,                 64'h0000_0000_0000_8001, 1, 0);
        vecs[4]  = mk(1, 0, 3'd2, 64'h2002,              64'h0,                 1, 6,  0, 64'h0,                 0, 64'h0,                 64'h0,                 64'h0,                 0, 1);
        vecs[5]  = mk(0, 1, 3'd3, 64'h3000,              64'h1122_3344_5566_7788, 0, 0, 1, 64'h0,               1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1122_3344_5566_7788, 64'h0,              0, 0);
        vecs[6]  = mk(0, 1, 3'd1, 64'h3006,              64'h1234_BEEF,         0, 0,  0, 64'h0,                 1, 64'hFFFF_0000_0000_0000, 64'hBEEF_0000_0000_0000, 64'h0,              0, 0);
        vecs[7]  = mk(0, 1, 3'd2, 64'h4004,              64'hFFFF_FFFF_CAFE_F00D, 0, 0, 2, 64'h0,               1, 64'hFFFF_FFFF_0000_0000, 64'hCAFE_F00D_0000_0000, 64'h0,              0, 0);
        vecs[8]  = mk(1, 0, 3'd0, 64'h5005,              64'h0,                 1, 8,  0, 64'h0000_8000_0000_0000, 1, 64'h0,               64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1, 0);
        vecs[9]  = mk(1, 0, 3'd4, 64'h5005,              64'h0,                 1, 9,  1, 64'h0000_8000_0000_0000, 1, 64'h0,               64'h0,                 64'h0000_0000_0000_0080, 1, 0);
        vecs[10] = mk(1, 0, 3'd6, 64'h6004,              64'h0,                 1, 10, 0, 64'h89AB_CDEF_0123_4567, 1, 64'h0,               64'h0,                 64'h0000_0000_89AB_CDEF, 1, 0);
        vecs[11] = mk(1, 0, 3'd2, 64'h6004,              64'h0,                 1, 11, 0, 64'h89AB_CDEF_0123_4567, 1, 64'h0,               64'h0,                 64'hFFFF_FFFF_89AB_CDEF, 1, 0);
        vecs[12] = mk(1, 0, 3'd7, 64'h7000,              64'h0,                 1, 12, 2, 64'hDEAD_BEEF_0000_0001, 1, 64'h0,               64'h0,                 64'hDEAD_BEEF_0000_0001, 1, 0);
        vecs[13] = mk(0, 1, 3'd3, 64'h3004,              64'h55,                0, 0,  0, 64'h0,                 0, 64'h0,                 64'h0,                 64'h0,                 0, 1);
        vecs[14] = mk(1, 0, 3'd1, 64'h2001,              64'h0,                 1, 13, 0, 64'h0,                 0, 64'h0,                 64'h0,                 64'h0,                 0, 1);
        vecs[15] = mk(0, 0, 3'd0, 64'hFFFF_0000_0000_0001, 64'h0,               0, 9,  0, 64'h0,                 0, 64'h0,                 64'h0,                 64'hFFFF_0000_0000_0001, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.stall",       stall,       1'b0);
        chk("rst.ram_req",     ram_req,     1'b0);
        chk("rst.ram_we",      ram_we,      1'b0);
        chk("rst.ram_addr",    ram_addr,    64'h0);
        chk("rst.wb_valid",    wb_valid,    1'b0);
        chk("rst.wb_data",     wb_data,     64'h0);
        chk("rst.wb_misalign", wb_misalign, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Ack while idle must not start anything.
        @(negedge clk);
        ram_ack = 1'b1;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        chk("idle_ack.wb_valid", wb_valid, 1'b0);
        chk("idle_ack.ram_req",  ram_req,  1'b0);
        chk("idle_ack.stall",    stall,    1'b0);

        // LD held 5 cycles without ack while EX presents an ADD.
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 3'd3, 64'h8000, 64'h0, 1'b1, 5'd14);
        @(posedge clk); #1;
        drive_ex(1'b0, 1'b0, 3'd0, 64'h4242, 64'h0, 1'b1, 5'd15);
        hold_addr = 64'h8000;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("hold.c%0d.stall", c),    stall,     1'b1);
            chk($sformatf("hold.c%0d.ram_req", c),  ram_req,   1'b1);
            chk($sformatf("hold.c%0d.ram_addr", c), ram_addr,  hold_addr);
            chk($sformatf("hold.c%0d.ram_we", c),   ram_we,    1'b0);
            chk($sformatf("hold.c%0d.wmask", c),    ram_wmask, 64'h0);
            chk($sformatf("hold.c%0d.wb_valid", c), wb_valid,  1'b0);
            if (c == 5) begin
                ram_ack = 1'b1;
                ram_rdata = 64'h0123_4567_89AB_CDEF;
            end
            @(posedge clk); #1;
        end
        ram_ack = 1'b0;
        ram_rdata = '0;
        chk("hold.ld.wb_valid",   wb_valid,   1'b1);
        chk("hold.ld.wb_data",    wb_data,    64'h0123_4567_89AB_CDEF);
        chk("hold.ld.wb_rd_addr", wb_rd_addr, 5'd14);
        chk("hold.ld.stall",      stall,      1'b0);
        @(posedge clk); #1;
        idle_ex();
        chk("hold.add.wb_valid",   wb_valid,   1'b1);
        chk("hold.add.wb_data",    wb_data,    64'h4242);
        chk("hold.add.wb_rd_addr", wb_rd_addr, 5'd15);
        chk("hold.add.ram_req",    ram_req,    1'b0);
        @(posedge clk); #1;
        chk("hold.add.pulse", wb_valid, 1'b0);

        // Reset two cycles into an unacked LD aborts it.
        @(negedge clk);
        drive_ex(1'b1, 1'b0, 3'd3, 64'h9000, 64'h0, 1'b1, 5'd16);
        @(posedge clk); #1;
        idle_ex();
        chk("abort.busy_req", ram_req, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort.ram_req",  ram_req,  1'b0);
        chk("abort.wb_valid", wb_valid, 1'b0);
        chk("abort.stall",    stall,    1'b0);
        ram_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ram_ack = 1'b0;
        @(posedge clk); #1;
        chk("abort.post.wb_valid", wb_valid, 1'b0);
        chk("abort.post.stall",    stall,    1'b0);
        @(negedge clk);
        drive_ex(1'b0, 1'b0, 3'd0, 64'h77, 64'h0, 1'b1, 5'd17);
        @(posedge clk); #1;
        idle_ex();
        chk("abort.alu.wb_valid",   wb_valid,   1'b1);
        chk("abort.alu.wb_data",    wb_data,    64'h77);
        chk("abort.alu.wb_rd_addr", wb_rd_addr, 5'd17);
        chk("abort.alu.stall",      stall,      1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
